// File: rtl/guess_judge.sv
// guess_judge: number-guessing game controller.
// Synchronizes and edge-detects the raw active-low guess and new-game keys,
// draws a secret digit from a free-running mod-10 counter, and judges guesses.
// Optional key debounce is enabled by defining GUESS_DEBOUNCE_EN.
module guess_judge #(
  parameter int unsigned MAX_TRIES       = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check,
  input  logic       new_game_n,
  input  logic [4:0] num,
  input  logic       nonerror,
  output logic [1:0] result,
  output logic [3:0] attempts,
  output logic       win,
  output logic       lose,
  output logic [3:0] secret
);

  localparam int unsigned KEYS  = 2;
  localparam int unsigned DB_W  = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOW  = 2'b01;
  localparam logic [1:0] RES_HIGH = 2'b10;
  localparam logic [1:0] RES_ERR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  // Reject illegal parameterisations at elaboration.
  if ((MAX_TRIES == 0) || (MAX_TRIES > 15) ||
      (DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_params
    $error("guess_judge: parameter out of legal range");
  end

  // ---------------------------------------------------------------------------
  // Key path: bit 1 = new game, bit 0 = guess.
  // ---------------------------------------------------------------------------
  logic [KEYS-1:0] key_raw;
  logic [KEYS-1:0] sync_a;
  logic [KEYS-1:0] sync_b;
  logic [KEYS-1:0] press_c;
  logic            ng_stb_c;
  logic            guess_stb_c;

  assign key_raw = {new_game_n, check};

  // Two-flop synchronizer; released (high) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
    end
  end

`ifdef GUESS_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt [KEYS];

  // Stable-low counter per key; saturates so each press strobes once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KEYS; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < KEYS; k++) begin
        if (sync_b[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] != DB_W'(DEBOUNCE_CYCLES)) begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Strobe on the cycle the low level completes its required run.
  always_comb begin
    press_c = '0;
    for (int k = 0; k < KEYS; k++) begin
      press_c[k] = ~sync_b[k] & (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
  end
`else
  logic [KEYS-1:0] level_prev;

  // Previous synchronized level for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= '1;
    end else begin
      level_prev <= sync_b;
    end
  end

  assign press_c = level_prev & ~sync_b;
`endif

  assign ng_stb_c    = press_c[1];
  assign guess_stb_c = press_c[0];

  // ---------------------------------------------------------------------------
  // Secret source: free-running mod-10 counter.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] digit;

  // Count 0..9 every clock, wrapping to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (digit == CNT_W'(9)) begin
      digit <= '0;
    end else begin
      digit <= digit + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [1:0]       result_nxt;
  logic [CNT_W-1:0] attempts_nxt;
  logic [CNT_W-1:0] secret_nxt;
  logic             win_nxt;
  logic             lose_nxt;
  logic             guess_valid_c;
  logic [CNT_W-1:0] attempts_inc_c;
  logic [4:0]       secret_ext_c;

  assign guess_valid_c  = nonerror && (num <= 5'd9);
  assign attempts_inc_c = attempts + CNT_W'(1);
  assign secret_ext_c   = {1'b0, secret};

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      result   <= RES_NONE;
      attempts <= '0;
      win      <= 1'b0;
      lose     <= 1'b0;
      secret   <= '0;
    end else begin
      state    <= state_nxt;
      result   <= result_nxt;
      attempts <= attempts_nxt;
      win      <= win_nxt;
      lose     <= lose_nxt;
      secret   <= secret_nxt;
    end
  end

  // Next state and next outputs; a new-game strobe overrides any guess.
  always_comb begin
    state_nxt    = state;
    result_nxt   = result;
    attempts_nxt = attempts;
    win_nxt      = win;
    lose_nxt     = lose;
    secret_nxt   = secret;

    if (ng_stb_c) begin
      secret_nxt   = digit;
      attempts_nxt = '0;
      win_nxt      = 1'b0;
      lose_nxt     = 1'b0;
      result_nxt   = RES_NONE;
      state_nxt    = S_PLAY;
    end else begin
      case (state)
        S_PLAY: begin
          if (guess_stb_c) begin
            if (!guess_valid_c) begin
              result_nxt = RES_ERR;
            end else if (num == secret_ext_c) begin
              attempts_nxt = attempts_inc_c;
              win_nxt      = 1'b1;
              result_nxt   = RES_NONE;
              state_nxt    = S_WIN;
            end else begin
              attempts_nxt = attempts_inc_c;
              result_nxt   = (num < secret_ext_c) ? RES_LOW : RES_HIGH;
              if (attempts_inc_c == CNT_W'(MAX_TRIES)) begin
                lose_nxt  = 1'b1;
                state_nxt = S_LOSE;
              end
            end
          end
        end
        default: begin
          // IDLE, WIN and LOSE ignore guesses and hold outputs.
        end
      endcase
    end
  end

endmodule
